rv32_csr_unit: RTL and testbench

Initiator side of the machine-mode CSR register file port: executes one Zicsr instruction (CSRRW/S/C and immediate forms) per `start` strobe. It drives `rd`/`wr`/`addr`/`data_i` of the CSR file, captures the registered read data, performs the read-modify-write and returns the old CSR value for the integer register file. It sits between the decode/execute stage and the CSR file, and flags illegal accesses to the trap path.

---
 rtl/rv32_csr_unit.sv | 227 ++++++++++++++++++++++
 tb/tb_rv32_csr_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_csr_unit.sv
// rv32_csr_unit
//   Initiator side of the machine-mode CSR file port. Executes one Zicsr
//   instruction (CSRRW/CSRRS/CSRRC and their immediate forms) per accepted
//   start strobe: optional read of the CSR, read-modify-write, optional write,
//   and hands the old CSR value back to the integer register file. Illegal
//   accesses (bad funct3, write to a read-only CSR, insufficient privilege, or
//   an error reported by the CSR file on the write) complete with illegal=1.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 request strobe, only taken while idle
//   funct3, csr_addr_i,   instruction fields, latched on start
//   rs1_idx, rs1_val,
//   rd_idx_i, priviledge
//   csr_rd, csr_wr,       CSR file strobes, address and write data
//   csr_addr, csr_wdata
//   csr_rdata             CSR file read data, valid the cycle after csr_rd
//   csr_error             CSR file error, valid the cycle after csr_wr
//   busy, done, illegal   instruction status
//   rd_we, rd_idx,        integer register file write-back of the old value
//   rd_data
//
// All outputs decode from the state register and latched data only, so no
// combinational path exists from the request inputs to any output.
module rv32_csr_unit #(
  parameter bit CHECK_PRIV = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [11:0] csr_addr_i,
  input  logic [4:0]  rs1_idx,
  input  logic [31:0] rs1_val,
  input  logic [4:0]  rd_idx_i,
  input  logic [1:0]  priviledge,
  output logic        csr_rd,
  output logic        csr_wr,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata,
  input  logic        csr_error,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic        rd_we,
  output logic [4:0]  rd_idx,
  output logic [31:0] rd_data
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_RDWAIT = 3'd2,
    S_WRITE  = 3'd3,
    S_WCHK   = 3'd4,
    S_DONE   = 3'd5,
    S_FAULT  = 3'd6
  } state_e;

  // funct3[1:0] selects the operation; funct3[2] only selects the operand.
  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  state_e      state_q, state_d;
  logic [11:0] addr_q;
  logic [1:0]  op_q;
  logic [31:0] operand_q;
  logic [4:0]  rd_idx_q;
  logic        do_read_q;
  logic        do_write_q;
  logic [31:0] old_q;
  logic [31:0] wdata_q;

  logic        is_rw_s;
  logic        do_read_s;
  logic        do_write_s;
  logic        fault_s;
  logic [31:0] operand_s;
  logic        accept_s;

  // New CSR value for a read-modify-write.
  function automatic logic [31:0] csr_new_value(input logic [1:0]  op,
                                                input logic [31:0] old,
                                                input logic [31:0] opnd);
    logic [31:0] res;
    case (op)
      OP_RW:   res = opnd;
      OP_RS:   res = old | opnd;
      OP_RC:   res = old & ~opnd;
      default: res = opnd;
    endcase
    return res;
  endfunction

  // Decode the incoming request; only consumed when it is accepted.
  always_comb begin
    is_rw_s    = (funct3[1:0] == OP_RW);
    operand_s  = funct3[2] ? {27'd0, rs1_idx} : rs1_val;
    // CSRRW with rd=x0 must not read the CSR (no read side effects).
    do_read_s  = !(is_rw_s && (rd_idx_i == 5'd0));
    // Set/clear with rs1=x0 (or zimm=0) must not write the CSR.
    do_write_s = is_rw_s || (rs1_idx != 5'd0);
    fault_s    = (funct3[1:0] == 2'b00)
              || (do_write_s && (csr_addr_i[11:10] == 2'b11))
              || ((CHECK_PRIV == 1'b1) && (csr_addr_i[9:8] > priviledge));
    accept_s   = (state_q == S_IDLE) && start;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (fault_s) begin
            state_d = S_FAULT;
          end else if (do_read_s) begin
            state_d = S_READ;
          end else begin
            state_d = S_WRITE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ:   state_d = S_RDWAIT;
      S_RDWAIT: begin
        if (do_write_q) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_WRITE:  state_d = S_WCHK;
      S_WCHK: begin
        if (csr_error) begin
          state_d = S_FAULT;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:   state_d = S_IDLE;
      S_FAULT:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Latch the request on acceptance and capture old/new values in RDWAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= 12'd0;
      op_q       <= 2'd0;
      operand_q  <= 32'd0;
      rd_idx_q   <= 5'd0;
      do_read_q  <= 1'b0;
      do_write_q <= 1'b0;
      old_q      <= 32'd0;
      wdata_q    <= 32'd0;
    end else if (accept_s) begin
      addr_q     <= csr_addr_i;
      op_q       <= funct3[1:0];
      operand_q  <= operand_s;
      rd_idx_q   <= rd_idx_i;
      do_read_q  <= do_read_s;
      do_write_q <= do_write_s;
      old_q      <= 32'd0;
      // Write-only path never visits RDWAIT, so the operand is the new value.
      wdata_q    <= operand_s;
    end else if (state_q == S_RDWAIT) begin
      old_q      <= csr_rdata;
      wdata_q    <= csr_new_value(op_q, csr_rdata, operand_q);
    end else begin
      old_q      <= old_q;
      wdata_q    <= wdata_q;
    end
  end

  // Output decode from state and latched data.
  always_comb begin
    csr_rd    = 1'b0;
    csr_wr    = 1'b0;
    csr_wdata = 32'd0;
    done      = 1'b0;
    illegal   = 1'b0;
    rd_we     = 1'b0;
    rd_idx    = 5'd0;
    rd_data   = 32'd0;
    busy      = (state_q != S_IDLE);
    if (busy) begin
      csr_addr = addr_q;
    end else begin
      csr_addr = 12'd0;
    end
    case (state_q)
      S_READ:  csr_rd = 1'b1;
      S_WRITE: begin
        csr_wr    = 1'b1;
        csr_wdata = wdata_q;
      end
      S_DONE: begin
        done    = 1'b1;
        rd_we   = do_read_q && (rd_idx_q != 5'd0);
        rd_idx  = rd_idx_q;
        rd_data = old_q;
      end
      S_FAULT: begin
        done    = 1'b1;
        illegal = 1'b1;
      end
      default: begin
        csr_rd = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rv32_csr_unit.sv
module tb_rv32_csr_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [11:0] csr_addr_i;
  logic [4:0]  rs1_idx;
  logic [31:0] rs1_val;
  logic [4:0]  rd_idx_i;
  logic [1:0]  priviledge;
  logic        csr_rd;
  logic        csr_wr;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_error;
  logic        busy;
  logic        done;
  logic        illegal;
  logic        rd_we;
  logic [4:0]  rd_idx;
  logic [31:0] rd_data;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] MVENDOR_ID = 32'h0000_0602;

  rv32_csr_unit #(.CHECK_PRIV(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .csr_addr_i(csr_addr_i), .rs1_idx(rs1_idx), .rs1_val(rs1_val),
    .rd_idx_i(rd_idx_i), .priviledge(priviledge),
    .csr_rd(csr_rd), .csr_wr(csr_wr), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_error(csr_error),
    .busy(busy), .done(done), .illegal(illegal), .rd_we(rd_we),
    .rd_idx(rd_idx), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Initial CSR contents: a few named CSRs fixed, the rest a hash of the address.
  function automatic logic [31:0] init_val(input logic [11:0] a);
    case (a)
      12'h300: return 32'h0000_0080;
      12'h304: return 32'h0000_00FF;
      12'hF11: return MVENDOR_ID;
      default: return {20'd0, a} * 32'h9E37_79B1 + 32'h1234_5678;
    endcase
  endfunction

  // The CSR file rejects writes to 0x7C0..0x7CF with an error.
  function automatic bit is_err_addr(input logic [11:0] a);
    return a[11:4] == 8'h7C;
  endfunction

  // ---------------- CSR file responder ----------------
  logic [31:0] file_mem [4096];
  logic        init_req;

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 4096; i++) file_mem[i] <= init_val(12'(i));
    end else if (csr_wr && !is_err_addr(csr_addr)) begin
      file_mem[csr_addr] <= csr_wdata;
    end
  end

  // Read data is garbage except in the cycle after csr_rd.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_rdata <= 32'd0;
      csr_error <= 1'b0;
    end else begin
      csr_rdata <= csr_rd ? file_mem[csr_addr] : $urandom;
      csr_error <= csr_wr && is_err_addr(csr_addr);
    end
  end

  // ---------------- reference model state ----------------
  logic [31:0] ref_mem [4096];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic any_out();
    return |{csr_rd, csr_wr, csr_addr, csr_wdata, busy, done, illegal,
             rd_we, rd_idx, rd_data};
  endfunction

  // Issue one instruction at a negedge with the DUT idle, observe until done,
  // compare against the architectural model, then check the unit returns idle.
  task automatic run_instr(input string tag, input logic [2:0] f3,
                           input logic [11:0] a, input logic [4:0] r1,
                           input logic [31:0] v1, input logic [4:0] rd,
                           input logic [1:0] pv, input bit hold);
    bit          legal, is_w, reads, writes, fault0, err, exp_ill, exp_we;
    logic [31:0] opnd, old, nv;
    int          exp_lat;
    int          rd_n, wr_n, rcyc, wcyc, done_c;
    logic [31:0] wval, rdat;
    logic [4:0]  ridx;
    logic        ill, we, both_hi, stray_we, busy_bad, addr_bad, wdata_bad;

    // Architectural model
    legal   = (f3 != 3'd0) && (f3 != 3'd4);
    is_w    = (f3 == 3'd1) || (f3 == 3'd5);
    opnd    = (f3 >= 3'd5) ? {27'd0, r1} : v1;
    reads   = !(is_w && rd == 5'd0);
    writes  = is_w || (r1 != 5'd0);
    fault0  = !legal || (writes && a >= 12'hC00) || (a[9:8] > pv);
    old     = reads ? ref_mem[a] : 32'd0;
    if (is_w)                          nv = opnd;
    else if (f3 == 3'd2 || f3 == 3'd6) nv = old | opnd;
    else                               nv = old & ~opnd;
    err     = !fault0 && writes && is_err_addr(a);
    exp_lat = fault0 ? 1 : 1 + 2 * int'(reads) + 2 * int'(writes);
    exp_ill = fault0 || err;
    exp_we  = !exp_ill && reads && (rd != 5'd0);

    start = 1'b1; funct3 = f3; csr_addr_i = a; rs1_idx = r1;
    rs1_val = v1; rd_idx_i = rd; priviledge = pv;
    rd_n = 0; wr_n = 0; rcyc = 0; wcyc = 0; done_c = 0;
    wval = 32'd0; rdat = 32'd0; ridx = 5'd0; ill = 1'b0; we = 1'b0;
    both_hi = 1'b0; stray_we = 1'b0; busy_bad = 1'b0; addr_bad = 1'b0; wdata_bad = 1'b0;

    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (!hold) begin
        // Request fields are latched; scrambling them must not matter.
        start = 1'b0; funct3 = 3'($urandom); csr_addr_i = 12'($urandom);
        rs1_idx = 5'($urandom); rs1_val = $urandom; rd_idx_i = 5'($urandom);
        priviledge = 2'($urandom);
      end
      @(negedge clk);
      if (csr_rd === 1'b1) begin rd_n++; rcyc = k; end
      if (csr_wr === 1'b1) begin wr_n++; wcyc = k; wval = csr_wdata; end
      if (csr_rd === 1'b1 && csr_wr === 1'b1) both_hi = 1'b1;
      if (csr_wr !== 1'b1 && csr_wdata !== 32'd0) wdata_bad = 1'b1;
      if (busy !== 1'b1) busy_bad = 1'b1;
      if (csr_addr !== a) addr_bad = 1'b1;
      if (done === 1'b1) begin
        done_c = k; ill = illegal; we = rd_we; ridx = rd_idx; rdat = rd_data;
        break;
      end
      if (rd_we !== 1'b0) stray_we = 1'b1;
    end
    start = 1'b0;

    chk({tag, ".done_cycle"}, 32'(done_c), 32'(exp_lat));
    chk({tag, ".illegal"}, 32'(ill), 32'(exp_ill));
    chk({tag, ".rd_we"}, 32'(we), 32'(exp_we));
    if (!exp_ill) begin
      chk({tag, ".rd_idx"}, 32'(ridx), 32'(rd));
      chk({tag, ".rd_data"}, rdat, old);
    end
    chk({tag, ".rd_strobes"}, 32'(rd_n), 32'(!fault0 && reads));
    chk({tag, ".wr_strobes"}, 32'(wr_n), 32'(!fault0 && writes));
    if (!fault0 && reads)  chk({tag, ".rd_cycle"}, 32'(rcyc), 32'd1);
    if (!fault0 && writes) begin
      chk({tag, ".wr_cycle"}, 32'(wcyc), 32'(1 + 2 * int'(reads)));
      chk({tag, ".wdata"}, wval, nv);
    end
    chk({tag, ".protocol"},
        {27'd0, both_hi, stray_we, busy_bad, addr_bad, wdata_bad}, 32'd0);

    @(posedge clk);
    @(negedge clk);
    chk({tag, ".idle_after"}, 32'(any_out()), 32'd0);

    if (!fault0 && writes && !err) ref_mem[a] = nv;
  endtask

  logic [11:0] pool [12] = '{12'h300, 12'h304, 12'h340, 12'h341, 12'hF11, 12'hF14,
                             12'h7C0, 12'h7C3, 12'h100, 12'h105, 12'h000, 12'hC00};

  initial begin
    rst_n = 1'b0; start = 1'b0; funct3 = 3'd0; csr_addr_i = 12'd0; rs1_idx = 5'd0;
    rs1_val = 32'd0; rd_idx_i = 5'd0; priviledge = 2'd0; init_req = 1'b1;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(12'(i));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'(any_out()), 32'd0);
    init_req = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 32'(any_out()), 32'd0);

    // Directed sequence
    run_instr("csrrs_mstatus",   3'b010, 12'h300, 5'd0,  32'h1234_5678, 5'd5, 2'b11, 1'b0);
    run_instr("csrrw_mscratch",  3'b001, 12'h340, 5'd1,  32'hDEAD_BEEF, 5'd0, 2'b11, 1'b0);
    run_instr("readback_mscr",   3'b010, 12'h340, 5'd0,  32'h0,         5'd7, 2'b11, 1'b0);
    run_instr("csrrci_mie",      3'b111, 12'h304, 5'h08, 32'hFFFF_FFFF, 5'd3, 2'b11, 1'b0);
    run_instr("csrrw_mvendorid", 3'b001, 12'hF11, 5'd2,  32'h5555_AAAA, 5'd4, 2'b11, 1'b0);
    run_instr("csrrs_mvendorid", 3'b010, 12'hF11, 5'd0,  32'h0,         5'd6, 2'b11, 1'b0);
    run_instr("umode_mstatus",   3'b010, 12'h300, 5'd0,  32'h0,         5'd5, 2'b00, 1'b0);
    run_instr("smode_sstatus",   3'b110, 12'h100, 5'd3,  32'h0,         5'd9, 2'b01, 1'b0);
    run_instr("csrrw_err_rd0",   3'b001, 12'h7C0, 5'd9,  32'h0BAD_F00D, 5'd0, 2'b11, 1'b0);
    run_instr("csrrw_err_rd",    3'b001, 12'h7C0, 5'd9,  32'h0BAD_F00D, 5'd8, 2'b11, 1'b0);
    run_instr("funct3_000",      3'b000, 12'h340, 5'd1,  32'h1,         5'd1, 2'b11, 1'b0);
    run_instr("funct3_100",      3'b100, 12'h340, 5'd1,  32'h1,         5'd1, 2'b11, 1'b0);
    run_instr("csrrc_mscratch",  3'b011, 12'h340, 5'd4,  32'h0000_FFFF, 5'd2, 2'b11, 1'b0);
    run_instr("start_held",      3'b010, 12'h341, 5'd1,  32'hF000_000F, 5'd2, 2'b11, 1'b1);
    run_instr("readback_mepc",   3'b010, 12'h341, 5'd0,  32'h0,         5'd2, 2'b11, 1'b0);

    // Asynchronous reset in RDWAIT
    start = 1'b1; funct3 = 3'b010; csr_addr_i = 12'h300; rs1_idx = 5'd0;
    rd_idx_i = 5'd5; priviledge = 2'b11;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    chk("midreset.read_strobe", 32'(csr_rd), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("midreset.busy_rdwait", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset.outputs_now", 32'(any_out()), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("midreset.outputs_held", 32'(any_out()), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreset.idle_release", 32'(any_out()), 32'd0);
    run_instr("after_reset_rs",  3'b010, 12'h300, 5'd0,  32'h0,         5'd5, 2'b11, 1'b0);

    // Randomized instructions
    for (int n = 0; n < 80; n++) begin
      logic [11:0] a;
      logic [4:0]  r1, rd;
      a  = ($urandom_range(0, 9) == 0) ? 12'($urandom) : pool[$urandom_range(0, 11)];
      r1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      run_instr($sformatf("rand%0d", n), 3'($urandom_range(0, 7)), a, r1, $urandom,
                rd, 2'($urandom_range(0, 3)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
